// File: rtl/pipeline_control_unit_if.sv
// ============================================================================
// Module   : pipeline_control_unit_if
// Brief    : Hazard/handshake inputs and latch enable/flush controls of the
//            pipeline control unit, plus its halt flag and perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_control_unit_if #(
    parameter int CNT_W = 16
);
    // Pipeline-side status
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             mem_halt;
    logic             ex_dREN;
    logic [4:0]       ex_wsel;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             br_taken;

    // Controls back to the PC and latches
    logic             pc_en;
    logic             fl_en;
    logic             fl_flush;
    logic             dl_en;
    logic             dl_flush;
    logic             el_en;
    logic             el_flush;
    logic             ml_en;
    logic             ml_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // master: the control unit itself; slave: the pipeline it steers
    modport master (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_wsel,
               id_rs, id_rt, id_uses_rt, br_taken,
        output pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
               ml_en, ml_flush, halt, stall_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_wsel,
               id_rs, id_rt, id_uses_rt, br_taken,
        input  pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
               ml_en, ml_flush, halt, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_control_unit.sv
// ============================================================================
// Module   : pipeline_control_unit
// Brief    : Stall/flush controller for the five-stage pipeline with halt FSM
//            and saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_control_unit #(
    parameter int CNT_W = 16
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    pipeline_control_unit_if.master bus
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_HALTING = 2'd1;
    localparam logic [1:0] c_HALTED  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_run, w_mem_busy, w_load_use;
    logic w_stall_inc, w_flush_inc;
    logic w_pc_en, w_fl_en, w_fl_flush, w_dl_en, w_dl_flush;
    logic w_el_en, w_el_flush, w_ml_en, w_ml_flush;

    // While reset is held the outputs behave as in RUN regardless of state.
    assign w_run      = RST || (r_state == c_RUN);
    assign w_mem_busy = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
    assign w_load_use = bus.ex_dREN && (bus.ex_wsel != 5'd0) &&
                        ((bus.ex_wsel == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_wsel == bus.id_rt)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_RUN:     if (!w_mem_busy && bus.mem_halt) w_next_state = c_HALTING;
            c_HALTING: w_next_state = c_HALTED;
            c_HALTED:  w_next_state = c_HALTED;
            default:   w_next_state = c_RUN;
        endcase
    end

    always_comb begin
        w_pc_en     = 1'b0;
        w_fl_en     = 1'b0;
        w_fl_flush  = 1'b0;
        w_dl_en     = 1'b0;
        w_dl_flush  = 1'b0;
        w_el_en     = 1'b0;
        w_el_flush  = 1'b0;
        w_ml_en     = 1'b0;
        w_ml_flush  = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (w_run) begin
            if (w_mem_busy) begin
                w_stall_inc = 1'b1;
            end else if (bus.mem_halt) begin
                // Halt is older than any branch in EX, so it takes priority.
                w_fl_en    = 1'b1;
                w_fl_flush = 1'b1;
                w_dl_en    = 1'b1;
                w_dl_flush = 1'b1;
                w_el_en    = 1'b1;
                w_el_flush = 1'b1;
                w_ml_en    = 1'b1;
            end else if (bus.br_taken) begin
                w_pc_en     = 1'b1;
                w_fl_en     = 1'b1;
                w_fl_flush  = 1'b1;
                w_dl_en     = 1'b1;
                w_dl_flush  = 1'b1;
                w_el_en     = 1'b1;
                w_ml_en     = 1'b1;
                w_flush_inc = 1'b1;
            end else if (w_load_use) begin
                w_dl_en     = 1'b1;
                w_dl_flush  = 1'b1;
                w_el_en     = 1'b1;
                w_ml_en     = 1'b1;
                w_stall_inc = 1'b1;
            end else if (!bus.ihit) begin
                w_fl_en     = 1'b1;
                w_fl_flush  = 1'b1;
                w_dl_en     = 1'b1;
                w_el_en     = 1'b1;
                w_ml_en     = 1'b1;
                w_stall_inc = 1'b1;
            end else begin
                w_pc_en = 1'b1;
                w_fl_en = 1'b1;
                w_dl_en = 1'b1;
                w_el_en = 1'b1;
                w_ml_en = 1'b1;
            end
        end else if (r_state == c_HALTING) begin
            // Let the instruction ahead of the halt retire, then empty MEM.
            w_ml_en    = 1'b1;
            w_ml_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_halt <= (w_next_state == c_HALTED);
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en     = w_pc_en;
    assign bus.fl_en     = w_fl_en;
    assign bus.fl_flush  = w_fl_flush;
    assign bus.dl_en     = w_dl_en;
    assign bus.dl_flush  = w_dl_flush;
    assign bus.el_en     = w_el_en;
    assign bus.el_flush  = w_el_flush;
    assign bus.ml_en     = w_ml_en;
    assign bus.ml_flush  = w_ml_flush;
    assign bus.halt      = r_halt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
